// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the parameterised UART receiver.
//   rx_state_t       receiver FSM state encoding
//   DATA_BITS_MIN/MAX  legal range of data bits per frame
//   OVERSAMPLE_MIN/MAX legal range of ticks per bit period (even values only)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int unsigned DATA_BITS_MIN  = 5;
  localparam int unsigned DATA_BITS_MAX  = 9;
  localparam int unsigned OVERSAMPLE_MIN = 8;
  localparam int unsigned OVERSAMPLE_MAX = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the asynchronous serial line plus a
// falling-edge detector on the synchronised value.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset; all flops reset to 1 (line idle)
//   rx_i    raw asynchronous serial line
//   rx_o    synchronised line level
//   fall_o  one-cycle pulse when the synchronised line goes high -> low
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  output logic rx_o,
  output logic fall_o
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= rx_i;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rx_o   = sync;
  assign fall_o = prev & ~sync;

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with a valid/ready output holding
// register, framing/parity error flags and an overrun pulse.
// Optional feature: define UART_RX_PARITY_EN to expect one parity bit after the
// data bits (parity_odd_i selects odd/even); otherwise parity_err_o is 0.
// Ports:
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   rx_i          asynchronous serial line, idle high
//   tick_i        oversampling strobe, Oversample strobes per bit
//   parity_odd_i  1 = odd parity, 0 = even parity
//   rx_data_o     received word (LSB first on the line)
//   rx_valid_o    rx_data_o and the error flags are valid
//   rx_ready_i    consumer accepts the held word
//   frame_err_o   a stop bit of the held word sampled low
//   parity_err_o  the held word failed its parity check
//   overrun_o     one-cycle pulse: a completed frame was dropped
//   busy_o        receiver is inside a frame
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned DataBits   = 8,
  parameter int unsigned Oversample = 16,
  parameter int unsigned StopBits   = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                rx_i,
  input  logic                tick_i,
  input  logic                parity_odd_i,
  output logic [DataBits-1:0] rx_data_o,
  output logic                rx_valid_o,
  input  logic                rx_ready_i,
  output logic                frame_err_o,
  output logic                parity_err_o,
  output logic                overrun_o,
  output logic                busy_o
);

  localparam int unsigned TW = $clog2(Oversample);
  localparam int unsigned BW = $clog2(DataBits + 1);

  localparam logic [TW-1:0] TICK_MID  = TW'(Oversample / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(Oversample - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DataBits - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(StopBits - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);

  rx_state_t           state;
  rx_state_t           state_next;
  logic                rx;
  logic                fall;
  logic [TW-1:0]       tick_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [DataBits-1:0] shreg;
  logic                frame_acc;
  logic                bit_tick;
  logic                shift_en;
  logic                stop_sample;
  logic                done;
  logic                load;
  logic [DataBits-1:0] data_hold;
  logic                valid_hold;
  logic                frame_err_hold;
  logic                overrun;

  uart_rx_sync u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .rx_i   (rx_i),
    .rx_o   (rx),
    .fall_o (fall)
  );

  // Tick on which a data/parity/stop bit is sampled (mid-bit, since the
  // counter was restarted at the middle of the start bit).
  assign bit_tick = tick_i && (tick_cnt == TICK_LAST);

  // --- FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --- FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (fall) state_next = START;
      START:  if (tick_i && (tick_cnt == TICK_MID)) state_next = rx ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   if (bit_tick && (bit_cnt == LAST_BIT)) state_next = PARITY;
      PARITY: if (bit_tick) state_next = STOP;
`else
      DATA:   if (bit_tick && (bit_cnt == LAST_BIT)) state_next = STOP;
`endif
      // Leaving mid stop bit lets the next start edge be seen immediately.
      STOP:   if (bit_tick && (bit_cnt == LAST_STOP)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // --- FSM outputs
  always_comb begin
    busy_o      = (state != IDLE);
    shift_en    = (state == DATA) && bit_tick;
    stop_sample = (state == STOP) && bit_tick;
    done        = (state == STOP) && bit_tick && (bit_cnt == LAST_STOP);
  end

  // A completed frame loads unless the previous word is still held and not
  // being accepted in this same cycle.
  assign load = done && (!valid_hold || rx_ready_i);

  // --- Counters and shift register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      frame_acc <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tick_cnt  <= '0;
          bit_cnt   <= '0;
          frame_acc <= 1'b0;
        end
        START:   if (tick_i) tick_cnt <= (tick_cnt == TICK_MID) ? '0 : tick_cnt + TICK_ONE;
        default: if (tick_i) tick_cnt <= bit_tick ? '0 : tick_cnt + TICK_ONE;
      endcase
      if (shift_en) begin
        shreg   <= {rx, shreg[DataBits-1:1]};
        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_ONE;
      end
      if (stop_sample) begin
        bit_cnt <= bit_cnt + BIT_ONE;
        if (!rx) frame_acc <= 1'b1;
      end
    end
  end

  // --- Output holding register and handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_hold      <= '0;
      valid_hold     <= 1'b0;
      frame_err_hold <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load) begin
        data_hold      <= shreg;
        frame_err_hold <= frame_acc | ~rx;
        valid_hold     <= 1'b1;
      end else if (done) begin
        overrun <= 1'b1;
      end else if (valid_hold && rx_ready_i) begin
        valid_hold <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_acc;
  logic parity_err_hold;

  // Error when the data bits plus parity bit do not have the requested sense.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      parity_acc      <= 1'b0;
      parity_err_hold <= 1'b0;
    end else begin
      if ((state == PARITY) && bit_tick) parity_acc <= ((^shreg) ^ rx) != parity_odd_i;
      if (load) parity_err_hold <= parity_acc;
    end
  end

  assign parity_err_o = parity_err_hold;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd_i;
  assign parity_err_o      = 1'b0;
`endif

  assign rx_data_o   = data_hold;
  assign rx_valid_o  = valid_hold;
  assign frame_err_o = frame_err_hold;
  assign overrun_o   = overrun;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed bench for uart_rx_param (8 data bits, 16x
// oversampling; a second instance uses two stop bits). A frame-level model
// predicts the held word, its flags and overrun pulses, and a compare process
// checks the DUT against it every cycle either side reports something.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int DB = 8;
  localparam int OS = 16;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          rx, rx2;
  logic          tick;
  logic          parity_odd;
  logic          ready, ready2;
  logic [DB-1:0] data, data2;
  logic          valid, valid2, ferr, ferr2, perr, perr2, ovr, ovr2, busy, busy2;

  int n_checks = 0;
  int n_fail   = 0;
  int ovr_cnt  = 0;

  // model state
  logic          m_valid, m_ferr, m_perr, m_ovr;
  logic [DB-1:0] m_data;
  logic          done_evt;
  logic [DB-1:0] d_data;
  logic          d_ferr, d_perr;

  always #5 clk = ~clk;

  uart_rx_param #(.DataBits(DB), .Oversample(OS), .StopBits(1)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .rx_i(rx), .tick_i(tick), .parity_odd_i(parity_odd),
    .rx_data_o(data), .rx_valid_o(valid), .rx_ready_i(ready), .frame_err_o(ferr),
    .parity_err_o(perr), .overrun_o(ovr), .busy_o(busy)
  );

  uart_rx_param #(.DataBits(DB), .Oversample(OS), .StopBits(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_ni), .rx_i(rx2), .tick_i(tick), .parity_odd_i(parity_odd),
    .rx_data_o(data2), .rx_valid_o(valid2), .rx_ready_i(ready2), .frame_err_o(ferr2),
    .parity_err_o(perr2), .overrun_o(ovr2), .busy_o(busy2)
  );

  // one-cycle tick every 4 clocks
  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached, actual running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_perr(input logic [DB-1:0] d, input logic pb);
`ifdef UART_RX_PARITY_EN
    return ((($countones(d) + int'(pb)) % 2) == 1) != parity_odd;
`else
    return 1'b0;
`endif
  endfunction

  // parity bit that makes the frame correct for the current sense
  function automatic logic good_pbit(input logic [DB-1:0] d);
    return (($countones(d) % 2) == 0) ? parity_odd : ~parity_odd;
  endfunction

  // Frame-level model: a completed frame becomes the held word unless a word
  // is held and not accepted in that cycle, in which case it is dropped.
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      m_valid <= 1'b0; m_data <= '0; m_ferr <= 1'b0; m_perr <= 1'b0; m_ovr <= 1'b0;
    end else begin
      m_ovr <= 1'b0;
      if (done_evt) begin
        if (!m_valid || ready) begin
          m_valid <= 1'b1; m_data <= d_data; m_ferr <= d_ferr; m_perr <= d_perr;
        end else begin
          m_ovr <= 1'b1;
        end
      end else if (m_valid && ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (valid || m_valid || ovr || m_ovr) begin
      check("model_valid", valid, m_valid);
      check("model_overrun", ovr, m_ovr);
      if (m_valid) begin
        check("model_data", data, m_data);
        check("model_frame_err", ferr, m_ferr);
        check("model_parity_err", perr, m_perr);
      end
    end
  end

  always @(negedge clk) if (ovr === 1'b1) ovr_cnt <= ovr_cnt + 1;

  task automatic hold_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (tick !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic set_line(input logic sel, input logic b);
    if (sel) rx2 = b;
    else     rx  = b;
  endtask

  // Sends one frame; the receiver samples the last stop bit on its 8th tick,
  // which is where the model event (and optional ready pulse) is placed.
  task automatic send_frame(input logic sel, input logic [DB-1:0] d, input logic pbit,
                            input int nstop, input logic s1, input logic s2,
                            input logic rdy_pulse);
    hold_ticks(1);
    #1 set_line(sel, 1'b0);
    hold_ticks(OS);
    for (int i = 0; i < DB; i++) begin
      #1 set_line(sel, d[i]);
      hold_ticks(OS);
    end
`ifdef UART_RX_PARITY_EN
    #1 set_line(sel, pbit);
    hold_ticks(OS);
`endif
    if (nstop == 2) begin
      #1 set_line(sel, s1);
      hold_ticks(OS);
    end
    #1 set_line(sel, (nstop == 2) ? s2 : s1);
    hold_ticks(OS / 2 - 1);
    repeat (3) @(posedge clk);
    #1;
    if (!sel) begin
      d_data   = d;
      d_ferr   = !s1 || ((nstop == 2) && !s2);
      d_perr   = exp_perr(d, pbit);
      done_evt = 1'b1;
    end
    if (rdy_pulse) ready = 1'b1;
    @(posedge clk);
    #1 done_evt = 1'b0;
    if (rdy_pulse) ready = 1'b0;
    hold_ticks(OS / 2);
  endtask

  task automatic consume();
    #1 ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
  endtask

  int base;

  initial begin
    rst_ni = 1'b0; rx = 1'b1; rx2 = 1'b1; ready = 1'b0; ready2 = 1'b0; parity_odd = 1'b1;
    done_evt = 1'b0; d_data = '0; d_ferr = 1'b0; d_perr = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_frame_err", ferr, 0);
    check("rst_parity_err", perr, 0);
    check("rst_overrun", ovr, 0);
    check("rst_busy", busy, 0);
    check("rst_busy2", busy2, 0);
    rst_ni = 1'b1;
    repeat (8) @(posedge clk);

    // 0xA5 held until accepted
    send_frame(1'b0, 8'hA5, good_pbit(8'hA5), 1, 1'b1, 1'b1, 1'b0);
    repeat (40) @(negedge clk);
    check("a5_valid", valid, 1);
    check("a5_data", data, 8'hA5);
    check("a5_frame_err", ferr, 0);
    check("a5_parity_err", perr, 0);
    check("a5_idle_busy", busy, 0);
    consume();
    @(negedge clk);
    check("a5_cleared", valid, 0);

`ifdef UART_RX_PARITY_EN
    send_frame(1'b0, 8'h03, 1'b0, 1, 1'b1, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check("par_bad_err", perr, 1);
    check("par_bad_data", data, 8'h03);
    consume();
    send_frame(1'b0, 8'h03, 1'b1, 1, 1'b1, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check("par_good_err", perr, 0);
    check("par_good_data", data, 8'h03);
    consume();
    parity_odd = 1'b0;
    send_frame(1'b0, 8'h03, 1'b0, 1, 1'b1, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check("par_even_err", perr, 0);
    consume();
    parity_odd = 1'b1;
`else
    send_frame(1'b0, 8'h03, 1'b0, 1, 1'b1, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check("nopar_err", perr, 0);
    check("nopar_data", data, 8'h03);
    consume();
`endif

    // false start: low for 4 ticks
    hold_ticks(1);
    #1 rx = 1'b0;
    hold_ticks(4);
    @(negedge clk);
    check("fs_busy_start", busy, 1);
    rx = 1'b1;
    hold_ticks(3);
    @(negedge clk);
    check("fs_busy_tick7", busy, 1);
    hold_ticks(1);
    @(negedge clk);
    check("fs_busy_tick8", busy, 0);
    repeat (300) @(negedge clk);
    check("fs_no_valid", valid, 0);

    // overrun: two frames, nothing accepted
    base = ovr_cnt;
    send_frame(1'b0, 8'h11, good_pbit(8'h11), 1, 1'b1, 1'b1, 1'b0);
    send_frame(1'b0, 8'h22, good_pbit(8'h22), 1, 1'b1, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check("ovr_pulses", ovr_cnt - base, 1);
    check("ovr_data", data, 8'h11);
    consume();

    // accept in the completion cycle: new word loads, no overrun
    base = ovr_cnt;
    send_frame(1'b0, 8'h11, good_pbit(8'h11), 1, 1'b1, 1'b1, 1'b0);
    send_frame(1'b0, 8'h22, good_pbit(8'h22), 1, 1'b1, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    check("same_cycle_pulses", ovr_cnt - base, 0);
    check("same_cycle_data", data, 8'h22);
    check("same_cycle_valid", valid, 1);
    consume();

    // stop bit low
    send_frame(1'b0, 8'h7E, good_pbit(8'h7E), 1, 1'b0, 1'b1, 1'b0);
    #1 rx = 1'b1;
    repeat (40) @(negedge clk);
    check("stop_low_ferr", ferr, 1);
    check("stop_low_data", data, 8'h7E);
    check("stop_low_busy", busy, 0);
    consume();

    // two stop bits
    send_frame(1'b1, 8'hC3, good_pbit(8'hC3), 2, 1'b1, 1'b1, 1'b0);
    repeat (40) @(negedge clk);
    check("sb2_good_valid", valid2, 1);
    check("sb2_good_data", data2, 8'hC3);
    check("sb2_good_ferr", ferr2, 0);
    #1 ready2 = 1'b1;
    @(posedge clk);
    #1 ready2 = 1'b0;
    send_frame(1'b1, 8'h5A, good_pbit(8'h5A), 2, 1'b1, 1'b0, 1'b0);
    #1 rx2 = 1'b1;
    repeat (40) @(negedge clk);
    check("sb2_bad_valid", valid2, 1);
    check("sb2_bad_data", data2, 8'h5A);
    check("sb2_bad_ferr", ferr2, 1);
    #1 ready2 = 1'b1;
    @(posedge clk);
    #1 ready2 = 1'b0;

    // reset during bit 4 while a word is held
    send_frame(1'b0, 8'h96, good_pbit(8'h96), 1, 1'b1, 1'b1, 1'b0);
    hold_ticks(1);
    #1 rx = 1'b0;
    hold_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      #1 rx = 1'b1;
      hold_ticks(OS);
    end
    #1 rx = 1'b0;
    hold_ticks(OS / 2);
    #1 rst_ni = 1'b0;
    @(negedge clk);
    check("midrst_valid", valid, 0);
    check("midrst_data", data, 0);
    check("midrst_frame_err", ferr, 0);
    check("midrst_parity_err", perr, 0);
    check("midrst_overrun", ovr, 0);
    check("midrst_busy", busy, 0);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_ni = 1'b1;
    repeat (OS * 4 * 12) @(negedge clk);
    check("postrst_no_valid", valid, 0);
    check("postrst_busy", busy, 0);
    send_frame(1'b0, 8'h3C, good_pbit(8'h3C), 1, 1'b1, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check("postrst_valid", valid, 1);
    check("postrst_data", data, 8'h3C);
    check("postrst_frame_err", ferr, 0);
    consume();
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter DataBits, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter Oversample, default 16, ticks per bit period (legal even values 8..16).
REQ-003 SHALL have parameter StopBits, default 1, stop bits checked per frame (legal 1 or 2).
REQ-004 SHALL have port clk_i  input  1  single clock; all flops rise on posedge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have port rx_i  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port tick_i  input  1  oversampling strobe, one clk_i cycle wide, Oversample per bit.
REQ-008 SHALL have port parity_odd_i  input  1  parity sense: 1 odd, 0 even; quasi-static.
REQ-009 SHALL have port rx_data_o  output  DataBits  received word, LSB first on the line.
REQ-010 SHALL have port rx_valid_o  output  1  rx_data_o and the error flags are valid.
REQ-011 SHALL have port rx_ready_i  input  1  consumer accepts the word when rx_valid_o is high.
REQ-012 SHALL have port frame_err_o  output  1  a stop bit of the held word sampled low.
REQ-013 SHALL have port parity_err_o  output  1  the held word failed its parity check.
REQ-014 SHALL have port overrun_o  output  1  one-cycle pulse: completed frame dropped.
REQ-015 SHALL have port busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 SHALL pass rx_i through a 2-flop synchroniser; sync flops reset to 1. All rx references below mean the synchronised value.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; the tick counter is $clog2(Oversample) bits and the bit counter is $clog2(DataBits+1) bits.
REQ-018 IDLE: a high-to-low transition on rx -> START with the tick counter cleared. A line held low SHALL NOT retrigger.
REQ-019 START: on the tick where counter == Oversample/2-1, rx high -> IDLE (false start, no output); rx low -> DATA, with both counters cleared.
REQ-020 DATA: on the tick where counter == Oversample-1, shift rx into bit DataBits-1 of the shift register (right shift) and clear the counter.
REQ-021 After the DataBits-th data sample, SHALL go to PARITY if parity is compiled in, else to STOP.
REQ-022 PARITY: sample at counter == Oversample-1. The error is set when XOR(data, parity bit) != parity_odd_i.
REQ-023 STOP: sample each of StopBits stop bits at counter == Oversample-1. Any low sample sets frame error.
REQ-024 On the last stop sample SHALL go directly to IDLE, mid stop bit, to allow back-to-back frames.
REQ-025 Completion SHALL load rx_data_o, frame_err_o and parity_err_o, and set rx_valid_o, on the clk_i edge after the final stop-sample tick.
REQ-026 rx_valid_o SHALL stay high, with rx_data_o and the flags stable, until a cycle with rx_valid_o && rx_ready_i; it clears on the next edge unless a new word loads on that edge.
REQ-027 At completion with rx_valid_o && !rx_ready_i, the new frame SHALL be discarded, the held word kept, and overrun_o pulsed for one cycle.
REQ-028 At completion with rx_valid_o && rx_ready_i in the same cycle, the new word SHALL load with rx_valid_o remaining high and no overrun.
REQ-029 Errored frames SHALL still be delivered, with the flags qualifying the data.
REQ-030 tick_i SHALL be ignored in IDLE. The FSM SHALL advance only on cycles with tick_i high.

Reset
REQ-031 rst_ni low SHALL asynchronously force: IDLE, counters 0, shift register 0, rx_data_o 0, all flags and pulses 0, busy_o 0, sync flops 1.
REQ-032 A reset mid-frame SHALL abandon the frame with no output. After release, reception restarts only on a new falling edge.

Configuration
REQ-033 Macro UART_RX_PARITY_EN defined: the PARITY state SHALL be present and one parity bit is expected after the data bits.
REQ-034 Macro UART_RX_PARITY_EN undefined: no PARITY state, parity_odd_i SHALL be ignored and parity_err_o SHALL be tied 0.

Structure
REQ-035 Package uart_pkg SHALL hold the rx_state_t enum (IDLE, START, DATA, PARITY, STOP) and the legal-range constants for DataBits and Oversample.
REQ-036 SHALL instantiate sub-module uart_rx_sync, which holds the 2-flop synchroniser and falling-edge detector and outputs the synchronised rx and a fall pulse.

Verification
REQ-037 Bench: 8N1, Oversample 16, frame 0xA5 -> rx_data_o=0xA5, rx_valid_o=1, frame_err_o=0, parity_err_o=0; held until rx_ready_i.
REQ-038 Bench: parity enabled, odd sense, 0x03 sent with parity bit 0 -> parity_err_o=1, rx_data_o=0x03; with parity bit 1 -> parity_err_o=0.
REQ-039 Bench: rx low for 4 ticks then high -> no rx_valid_o, busy_o returns to 0 after the Oversample/2 tick.
REQ-040 Bench: two frames 0x11 then 0x22 with rx_ready_i=0 -> rx_data_o=0x11, one overrun_o pulse; repeat with rx_ready_i=1 at the second completion -> rx_data_o=0x22, no pulse.
REQ-041 Bench: stop bit driven low on 0x7E -> frame_err_o=1; StopBits=2 with the second stop bit low -> frame_err_o=1.
REQ-042 Bench: rst_ni pulsed low during bit 4 -> all outputs 0 and no word delivered; the next full frame 0x3C is received correctly.
